pipe_cnt_bits: RTL and testbench
================================

# pipe_cnt_bits

Pipelined, flow-controlled population counter: counts bits of a wide input word equal to the active level, using a registered adder tree with a configurable register spacing. It sits where a single-cycle combinational bit counter cannot meet timing (wide issue masks, free-list occupancy, vector-mask counts) and adds valid/ready flow control and an optional running accumulator.

## Interface
- IN, 128: input word width, ≥1.
- ACT, `High: bit level that is counted (`High or `Low from stddef.vh).
- REG_LVL, 2: adder-tree levels between pipeline registers, ≥1.
- ACC_W, 32: accumulator width, ≥OUT.
- OUT, $clog2(IN)+1: count width (derived; do not override).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts input this cycle.
- in  in  IN  word to count.
- out_valid  out  1  count valid.
- out_ready  in  1  downstream accepts count.
- out  out  OUT  number of bits of the accepted word equal to ACT.
- acc_clr  in  1  synchronous accumulator clear (accumulator build only).
- acc  out  ACC_W  running total of transferred counts (accumulator build only).
- acc_sat  out  1  sticky: accumulator has saturated (accumulator build only).

## Operation
- Input padded to EIN = 2^$clog2(IN) with non-counting bits; level 0 converts each bit to (bit==ACT); levels 1..LOG2_IN pairwise add, level k results k+1 bits wide, no truncation.
- Pipeline register after every REG_LVL adder levels and always at the output; number of register stages S = max(1, ceil(LOG2_IN/REG_LVL)). IN=1: S=1, out = (in==ACT).
- Each stage holds data plus a valid bit. Global advance: adv = out_ready | ~out_valid. in_ready = adv. When adv=1 all stages shift; stage 0 loads valid = in_valid. When adv=0 all stages hold.
- Input beat transfers when in_valid & in_ready; output beat transfers when out_valid & out_ready.
- Beats are delivered in order, none lost or duplicated; bubbles propagate (no collapse).
- Accumulator: on output transfer acc ← acc + out, saturating at 2^ACC_W−1; acc_sat sets when a saturating add clips or lands exactly on max, stays set until acc_clr. acc_clr with simultaneous transfer: acc ← out, acc_sat ← (out == 2^ACC_W−1). acc_clr alone: acc ← 0, acc_sat ← 0.
- reset mid-operation discards all in-flight beats.

## Timing
- Reset values: out_valid=0, out=0, all stage valid bits 0, acc=0, acc_sat=0. in_ready=1 during and after reset (combinational from out_valid).
- Latency: beat accepted at cycle t appears on out at t+S when unstalled.
- Throughput: one beat per cycle while out_ready=1.
- in_ready depends combinationally on out_ready (no skid buffer); out, out_valid registered.
- Holding out_ready=0 with out_valid=1 freezes out/out_valid and every stage.
- acc/acc_sat registered; updated value visible the cycle after the transfer.

## Configuration
- PIPE_CNT_BITS_ACC_EN defined: acc_clr, acc, acc_sat and accumulator logic present as above.
- Undefined: ports remain; acc and acc_sat tied 0, acc_clr ignored; no accumulator flops.

## Test plan
- IN=128, REG_LVL=2, ACT=`High, out_ready=1: in = all ones at t → out=128, out_valid=1 at t+4; in = 0x…0001 → out=1; in=0 → out=0 with out_valid=1.
- IN=13, ACT=`Low: in=13'h1FFE → out=1; in=0 → out=13; padding bits never counted.
- Back-to-back 8 random beats, out_ready toggled 1,0,0,1,…: outputs match reference popcounts in order, out stable while out_ready=0, in_ready=0 exactly when out_valid=1 & out_ready=0.
- IN=1, REG_LVL=3: in=1 → out=1 one cycle later; ACT=`Low, in=1 → out=0.
- Accumulator build, ACC_W=8, IN=128: three all-ones beats → acc 128, 255 (acc_sat=1), 255; then acc_clr with beat of count 5 → acc=5, acc_sat=0.
- Assert reset with 3 beats in flight → next cycle out_valid=0, acc=0; first post-reset beat emerges after S cycles with correct count.

Source files
------------

// File: rtl/pipe_cnt_bits.sv
// pipe_cnt_bits: pipelined count of input bits equal to ACT (registered adder tree), optional running accumulator.
// Latency: S = max(1, ceil(log2(IN)/REG_LVL)) cycles from input transfer to out; one beat per cycle.
// Backpressure: out_valid & ~out_ready freezes every stage; in_ready = out_ready | ~out_valid (combinational, no skid).
// Build option: define PIPE_CNT_BITS_ACC_EN to include the saturating accumulator (acc, acc_sat, acc_clr).

`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module pipe_cnt_bits #(
    parameter int   IN      = 128,
    parameter logic ACT     = `High,
    parameter int   REG_LVL = 2,
    parameter int   ACC_W   = 32,
    parameter int   OUT     = $clog2(IN) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN-1:0]    in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT-1:0]   out,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc,
    output logic             acc_sat
);

    localparam int LOG2_IN = $clog2(IN);
    localparam int EIN     = 1 << LOG2_IN;
    localparam int S       = (LOG2_IN == 0) ? 1 : (LOG2_IN + REG_LVL - 1) / REG_LVL;

    // One shared advance signal: the whole pipe moves together or not at all.
    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Level 0: mark bits equal to ACT; padding up to a power of two is left at 0 so it never counts.
    logic [EIN-1:0] hit;
    always_comb begin
        hit         = '0;
        hit[IN-1:0] = in ~^ {IN{ACT}};
    end

    // Adder tree: level k holds EIN>>k partial counts, each k+1 bits wide (no truncation).
    // A level is registered every REG_LVL adder levels and always at the final level.
    for (genvar k = 0; k <= LOG2_IN; k++) begin : g_lvl
        localparam int W      = k + 1;
        localparam int N      = EIN >> k;
        localparam bit IS_REG = (k == LOG2_IN) || ((k > 0) && ((k % REG_LVL) == 0));

        logic [W-1:0] sum [N];
        logic [W-1:0] val [N];

        if (k == 0) begin : g_leaf
            // Leaf level: each single hit bit is its own 1-bit count.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    sum[i] = hit[i];
                end
            end
        end else begin : g_add
            // Pairwise add of the previous level, widened by one bit.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    sum[i] = {1'b0, g_lvl[k-1].val[2*i]} + {1'b0, g_lvl[k-1].val[2*i+1]};
                end
            end
        end

        if (IS_REG) begin : g_reg
            logic [W-1:0] dat_d [N];
            logic [W-1:0] dat_q [N];

            // Stage data shifts in on advance and holds while stalled.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    dat_d[i] = adv ? sum[i] : dat_q[i];
                end
            end

            // Stage data register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < N; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < N; i++) begin
                        dat_q[i] <= dat_d[i];
                    end
                end
            end

            // Registered level feeds the next adder level.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    val[i] = dat_q[i];
                end
            end
        end else begin : g_comb
            // Unregistered level passes straight through to the next adder level.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    val[i] = sum[i];
                end
            end
        end
    end

    assign out = g_lvl[LOG2_IN].val[0];

    // Valid bits travel alongside the data; bubbles are kept, not collapsed.
    logic [S-1:0] vld_d;
    logic [S-1:0] vld_q;

    always_comb begin
        vld_d = vld_q;
        if (adv) begin
            vld_d[0] = in_valid;
            for (int s = 1; s < S; s++) begin
                vld_d[s] = vld_q[s-1];
            end
        end
    end

    // Valid chain register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q[S-1];

    logic out_xfer;
    assign out_xfer = out_valid & out_ready;

`ifdef PIPE_CNT_BITS_ACC_EN
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [ACC_W-1:0] out_ext;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_q;
    logic             acc_sat_d;
    logic             acc_sat_q;

    // Running total of transferred counts; clips at max and flags it until cleared.
    always_comb begin
        out_ext          = '0;
        out_ext[OUT-1:0] = out;
        acc_sum          = {1'b0, acc_q} + {1'b0, out_ext};
        acc_d            = acc_q;
        acc_sat_d        = acc_sat_q;
        if (acc_clr) begin
            if (out_xfer) begin
                acc_d     = out_ext;
                acc_sat_d = (out_ext == ACC_MAX);
            end else begin
                acc_d     = '0;
                acc_sat_d = 1'b0;
            end
        end else if (out_xfer) begin
            if (acc_sum >= {1'b0, ACC_MAX}) begin
                acc_d     = ACC_MAX;
                acc_sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
        end
    end

    assign acc     = acc_q;
    assign acc_sat = acc_sat_q;
`else
    logic unused_acc;
    assign unused_acc = acc_clr | out_xfer;
    assign acc        = '0;
    assign acc_sat    = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_cnt_bits.sv
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module tb_pipe_cnt_bits;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Main DUT: IN=128, REG_LVL=2, ACT=High, ACC_W=8 (S=4)
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_acc_clr, a_acc_sat;
    logic [127:0] a_in;
    logic [7:0]   a_out, a_acc;

    // IN=13, ACT=Low (S=2)
    logic         b_in_valid, b_in_ready, b_out_valid, b_acc_sat;
    logic [12:0]  b_in;
    logic [4:0]   b_out;
    logic [31:0]  b_acc;

    // IN=1, REG_LVL=3, ACT=High / ACT=Low (S=1)
    logic         c_in_valid, c_in_ready, c_out_valid, c_acc_sat, c_in, c_out;
    logic [31:0]  c_acc;
    logic         d_in_valid, d_in_ready, d_out_valid, d_acc_sat, d_in, d_out;
    logic [31:0]  d_acc;

    logic one = 1'b1;
    logic zero = 1'b0;

    pipe_cnt_bits #(.IN(128), .ACT(`High), .REG_LVL(2), .ACC_W(8)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .in(a_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out),
        .acc_clr(a_acc_clr), .acc(a_acc), .acc_sat(a_acc_sat));

    pipe_cnt_bits #(.IN(13), .ACT(`Low), .REG_LVL(2), .ACC_W(32)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in),
        .out_valid(b_out_valid), .out_ready(one), .out(b_out),
        .acc_clr(zero), .acc(b_acc), .acc_sat(b_acc_sat));

    pipe_cnt_bits #(.IN(1), .ACT(`High), .REG_LVL(3), .ACC_W(32)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready), .in(c_in),
        .out_valid(c_out_valid), .out_ready(one), .out(c_out),
        .acc_clr(zero), .acc(c_acc), .acc_sat(c_acc_sat));

    pipe_cnt_bits #(.IN(1), .ACT(`Low), .REG_LVL(3), .ACC_W(32)) u_d (
        .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready), .in(d_in),
        .out_valid(d_out_valid), .out_ready(one), .out(d_out),
        .acc_clr(zero), .acc(d_acc), .acc_sat(d_acc_sat));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [127:0] words [8];
    int           exp_q [$];
    int           sent, got, cyc;
    logic [7:0]   held;
    logic         stalled, do_in;

    initial begin
        a_in_valid = 0; a_in = '0; a_out_ready = 1; a_acc_clr = 0;
        b_in_valid = 0; b_in = '0;
        c_in_valid = 0; c_in = 0;
        d_in_valid = 0; d_in = 0;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out", a_out, 0);
        chk("rst_acc", a_acc, 0);
        chk("rst_acc_sat", a_acc_sat, 0);
        chk("rst_b_valid", b_out_valid, 0);
        reset = 0;
        tick();
        chk("post_rst_in_ready", a_in_ready, 1);

        // Small configurations: IN=13 Low, IN=1 High/Low
        b_in = 13'h1FFE; b_in_valid = 1;
        c_in = 1; c_in_valid = 1;
        d_in = 1; d_in_valid = 1;
        tick();
        chk("in1_hi_valid", c_out_valid, 1);
        chk("in1_hi_out", c_out, 1);
        chk("in1_lo_valid", d_out_valid, 1);
        chk("in1_lo_out", d_out, 0);
        chk("in13_early", b_out_valid, 0);
        b_in = 13'h0000;
        c_in_valid = 0; d_in_valid = 0;
        tick();
        chk("in13_a_valid", b_out_valid, 1);
        chk("in13_a_out", b_out, 1);
        chk("in1_hi_drain", c_out_valid, 0);
        b_in_valid = 0;
        tick();
        chk("in13_b_valid", b_out_valid, 1);
        chk("in13_b_out", b_out, 13);
        tick();
        chk("in13_drain", b_out_valid, 0);

        // Latency and back-to-back on IN=128: all ones, single bit, zero
        a_in = '1; a_in_valid = 1;
        tick();
        a_in = 128'h1;
        tick();
        a_in = '0;
        tick();
        a_in_valid = 0;
        chk("lat_not_yet", a_out_valid, 0);
        tick();
        chk("lat_valid", a_out_valid, 1);
        chk("ones_out", a_out, 128);
        tick();
        chk("one_bit_out", a_out, 1);
        tick();
        chk("zero_valid", a_out_valid, 1);
        chk("zero_out", a_out, 0);
`ifndef PIPE_CNT_BITS_ACC_EN
        chk("acc_tied", a_acc, 0);
        chk("acc_sat_tied", a_acc_sat, 0);
`endif
        tick();
        chk("drained", a_out_valid, 0);

        // Back-to-back random beats with out_ready pattern 1,0,0,1
        for (int i = 0; i < 8; i++) words[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        words[2] = '0;
        words[5] = '1;
        sent = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 80) begin
            a_out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            a_in_valid  = (sent < 8);
            a_in        = (sent < 8) ? words[sent] : '0;
            #1;
            chk("in_ready_rule", a_in_ready, !(a_out_valid && !a_out_ready));
            do_in = a_in_valid && a_in_ready;
            if (do_in) exp_q.push_back($countones(words[sent]));
            if (a_out_valid && a_out_ready) begin
                if (exp_q.size() == 0) chk("extra_out", a_out_valid, 0);
                else chk("seq_out", a_out, exp_q.pop_front());
                got++;
            end
            stalled = a_out_valid && !a_out_ready;
            held    = a_out;
            tick();
            if (do_in) sent++;
            if (stalled) begin
                chk("held_valid", a_out_valid, 1);
                chk("held_out", a_out, held);
            end
            cyc++;
        end
        chk("seq_count", got, 8);
        a_in_valid = 0; a_out_ready = 1;
        for (int i = 0; i < 6; i++) tick();
        chk("seq_drained", a_out_valid, 0);

`ifdef PIPE_CNT_BITS_ACC_EN
        // Accumulator: clear alone, three saturating adds, clear with transfer
        a_acc_clr = 1;
        tick();
        a_acc_clr = 0;
        chk("clr_acc", a_acc, 0);
        chk("clr_sat", a_acc_sat, 0);
        a_in_valid = 1; a_in = '1;
        tick(); tick(); tick();
        a_in = 128'h1F;
        tick();
        a_in_valid = 0;
        tick();
        chk("acc_1", a_acc, 128);
        chk("acc_1_sat", a_acc_sat, 0);
        tick();
        chk("acc_2", a_acc, 255);
        chk("acc_2_sat", a_acc_sat, 1);
        tick();
        chk("acc_3", a_acc, 255);
        chk("acc_3_sat", a_acc_sat, 1);
        chk("acc_d_out", a_out, 5);
        a_acc_clr = 1;
        tick();
        a_acc_clr = 0;
        chk("acc_clr_xfer", a_acc, 5);
        chk("acc_clr_xfer_sat", a_acc_sat, 0);
        tick();
`endif

        // Reset with three beats in flight
        a_in_valid = 1; a_in = '1;
        tick(); tick(); tick();
        a_in_valid = 0;
        reset = 1;
        tick();
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_acc", a_acc, 0);
        chk("mid_rst_in_ready", a_in_ready, 1);
        reset = 0;
        tick();
        a_in = 128'hF0F0; a_in_valid = 1;
        tick();
        a_in_valid = 0;
        tick(); tick();
        chk("post_rst_no_stale", a_out_valid, 0);
        tick();
        chk("post_rst_valid", a_out_valid, 1);
        chk("post_rst_out", a_out, 8);
        tick();
        chk("post_rst_drain", a_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
